// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked MIPS data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int DMEM_MAX_WAIT = 15;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory: store byte enables and
// replicated data, load extraction with sign/zero extension, alignment checking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        align_err
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Offset 0 is the least significant byte (little-endian lanes).
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'd0;
        align_err = 1'b0;
        rbyte     = rword[{offset, 3'b000} +: 8];
        rhalf     = rword[{offset[1], 4'b0000} +: 16];
        case (mem_size_t'(size))
            MEM_BYTE: begin
                byte_en   = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            MEM_HALF: begin
                align_err = offset[0];
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            MEM_WORD: begin
                align_err = (offset != 2'b00);
                byte_en   = 4'b1111;
                rdata_ext = rword;
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request handshake, configurable wait states,
// sub-word accesses and error reporting.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_t state, next_state;
    logic [3:0]  cnt;
    logic        accept;
    logic        commit;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_unsigned;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic        range_err;
    logic        access_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        align_err;

    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit edge is also the acceptance edge, so the
    // live request fields must be used; otherwise the latched copy is used.
    always_comb begin
        sel_we       = lat_we;
        sel_addr     = lat_addr;
        sel_wdata    = lat_wdata;
        sel_size     = lat_size;
        sel_unsigned = lat_unsigned;
        if (state != WAIT) begin
            sel_we       = req_we;
            sel_addr     = req_addr;
            sel_wdata    = req_wdata;
            sel_size     = req_size;
            sel_unsigned = req_unsigned;
        end
    end

    assign word_idx   = sel_addr[AW+1:2];
    assign range_err  = |sel_addr[31:AW+2];
    assign access_err = align_err || range_err;

    dmem_lane_align u_align (
        .size        (sel_size),
        .offset      (sel_addr[1:0]),
        .is_unsigned (sel_unsigned),
        .wdata       (sel_wdata),
        .rword       (mem[word_idx]),
        .byte_en     (byte_en),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext),
        .align_err   (align_err)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) next_state = RESP;
            RESP: begin
                if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                else        next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        commit = (next_state == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            lat_we       <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt          <= WAIT_LOAD;
                lat_we       <= req_we;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= commit;
            if (commit) begin
                resp_err   <= access_err;
                resp_rdata <= (access_err || sel_we) ? 32'd0 : rdata_ext;
            end
        end
    end

    // The array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (commit && sel_we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_hs.sv
// Testbench for dmem_hs: two instances (0 and 3 wait states) driven by directed
// and random accesses, checked against a byte-array reference model.
module tb_dmem_hs;

    localparam int DEPTH = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk;
    logic [1:0]  reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata [2];

    int errors = 0;
    int checks = 0;
    int wait_of [2] = '{0, 3};

    logic [7:0] mdl [2][NBYTES];
    bit         wrt [2][NBYTES];

    dmem_hs #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_hs #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset_n(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: error rules, then byte-wise little-endian read/write.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic uns, output logic [31:0] obs_data,
                                 output logic obs_err);
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] raw;
        bit          known;
        int          nb;
        int          a;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
        exp_data = 32'd0;
        known = 1'b1;
        a = int'(addr[9:0]);
        if (!exp_err && !we) begin
            raw = 32'd0;
            for (int i = 0; i < nb; i++) begin
                raw |= 32'(mdl[d][a+i]) << (8 * i);
                known &= wrt[d][a+i];
            end
            if (nb == 1)      exp_data = uns ? raw : {{24{raw[7]}}, raw[7:0]};
            else if (nb == 2) exp_data = uns ? raw : {{16{raw[15]}}, raw[15:0]};
            else              exp_data = raw;
        end
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid[d] = 1'b1;
        checkOutput("ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (we && !exp_err) begin
            for (int i = 0; i < nb; i++) begin
                mdl[d][a+i] = wdata[8*i +: 8];
                wrt[d][a+i] = 1'b1;
            end
        end
        for (int i = 0; i < wait_of[d]; i++) begin
            @(negedge clk);
            checkOutput("valid_early", 32'(resp_valid[d]), 32'd0);
            checkOutput("ready_in_wait", 32'(req_ready[d]), 32'd0);
        end
        @(negedge clk);
        checkOutput("resp_valid", 32'(resp_valid[d]), 32'd1);
        checkOutput("resp_err", 32'(resp_err[d]), 32'(exp_err));
        if (known) checkOutput("resp_rdata", resp_rdata[d], exp_data);
        obs_data = resp_rdata[d];
        obs_err  = resp_err[d];
        @(negedge clk);
        checkOutput("valid_one_cycle", 32'(resp_valid[d]), 32'd0);
    endtask

    task automatic randomRun(input int d, input int n);
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] od;
        logic        oe;
        for (int k = 0; k < n; k++) begin
            size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) addr = 32'(NBYTES) + 32'($urandom_range(0, 63));
            applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom, size,
                          1'($urandom_range(0, 1)), od, oe);
        end
    endtask

    initial begin
        logic [31:0] od;
        logic        oe;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NBYTES; i++) wrt[d][i] = 1'b0;
        reset_n = 2'b00;
        req_valid = 2'b00;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_ready", 32'(req_ready[d]), 32'd1);
            checkOutput("reset_valid", 32'(resp_valid[d]), 32'd0);
            checkOutput("reset_rdata", resp_rdata[d], 32'd0);
            checkOutput("reset_err", 32'(resp_err[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset_n = 2'b11;

        $display("[TB] directed accesses, zero wait states");
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, od, oe);
        applyStimulus(0, 1'b1, 32'h4, 32'hA5A5A5A5, 2'd2, 1'b0, od, oe);
        applyStimulus(0, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("lw_4", od, 32'hA5A5A5A5);
        applyStimulus(0, 1'b1, 32'h8, 32'h11223344, 2'd2, 1'b0, od, oe);
        applyStimulus(0, 1'b1, 32'hA, 32'h000000FF, 2'd0, 1'b0, od, oe);
        applyStimulus(0, 1'b0, 32'hA, 32'h0, 2'd0, 1'b0, od, oe);
        checkOutput("lb_a", od, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, 32'hA, 32'h0, 2'd0, 1'b1, od, oe);
        checkOutput("lbu_a", od, 32'h000000FF);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 2'd1, 1'b0, od, oe);
        checkOutput("lh_8", od, 32'h00003344);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("lw_8", od, 32'h11FF3344);

        applyStimulus(0, 1'b0, 32'h6, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("err_lw_6", {od[30:0], oe}, 32'd1);
        applyStimulus(0, 1'b1, 32'h9, 32'hBEEF, 2'd1, 1'b0, od, oe);
        checkOutput("err_sh_9", {od[30:0], oe}, 32'd1);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("lw_8_after_err", od, 32'h11FF3344);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 2'd3, 1'b0, od, oe);
        checkOutput("err_size3", {od[30:0], oe}, 32'd1);
        applyStimulus(0, 1'b0, 32'(NBYTES), 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("err_range", {od[30:0], oe}, 32'd1);

        $display("[TB] back-to-back store then load");
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h5555AAAA;
        req_size = 2'd2; req_unsigned = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mdl[0][16+i] = 8'(32'h5555AAAA >> (8 * i));
            wrt[0][16+i] = 1'b1;
        end
        @(negedge clk);
        checkOutput("b2b_store_valid", 32'(resp_valid[0]), 32'd1);
        checkOutput("b2b_ready_in_resp", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("b2b_load_valid", 32'(resp_valid[0]), 32'd1);
        checkOutput("b2b_load_data", resp_rdata[0], 32'h5555AAAA);
        @(negedge clk);

        $display("[TB] three wait states with reset during a pending store");
        applyStimulus(1, 1'b1, 32'h4, 32'hA5A5A5A5, 2'd2, 1'b0, od, oe);
        applyStimulus(1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("w3_lw_4", od, 32'hA5A5A5A5);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
        req_size = 2'd2; req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("w3_ready_wait", 32'(req_ready[1]), 32'd0);
        reset_n[1] = 1'b0;
        #1;
        checkOutput("w3_reset_ready", 32'(req_ready[1]), 32'd1);
        checkOutput("w3_reset_rdata", resp_rdata[1], 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("w3_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        reset_n[1] = 1'b1;
        applyStimulus(1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, od, oe);
        checkOutput("w3_store_dropped", od, 32'hA5A5A5A5);

        $display("[TB] random accesses");
        randomRun(0, 60);
        randomRun(1, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
